// File: rtl/video_source_arbiter_if.sv
// Video source arbiter bus.
// Groups the per-source request/grant handshake, the shared timing inputs,
// the packed pixel inputs of all sources and the registered video output.
//   req      [N]      per-source request level
//   grant    [N]      one-hot owner, zero when idle
//   live              owner's pixels are being passed through
//   de_in / hsync_in / vsync_in   timing generator inputs
//   pix_in   [N*24]   source i RGB at [24i+23:24i] as {r,g,b}
//   r, g, b  [8]      video output
//   de / hsync / vsync            timing outputs, one cycle late
// slave  : the arbiter side.
// master : the side driving sources and timing and consuming the video.
interface video_source_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            live;
  logic            de_in;
  logic            hsync_in;
  logic            vsync_in;
  logic [N*24-1:0] pix_in;
  logic [7:0]      r;
  logic [7:0]      g;
  logic [7:0]      b;
  logic            de;
  logic            hsync;
  logic            vsync;

  modport slave (
    input  req, de_in, hsync_in, vsync_in, pix_in,
    output grant, live, r, g, b, de, hsync, vsync
  );

  modport master (
    output req, de_in, hsync_in, vsync_in, pix_in,
    input  grant, live, r, g, b, de, hsync, vsync
  );
endinterface

// File: rtl/video_source_arbiter.sv
// Frame-synchronous arbiter that shares one video output among N sources
// driven by a common timing generator. Ownership only moves on the rising
// edge of vsync_in (round-robin, with an optional minimum show quantum), and
// every new owner is blanked for MUTE whole frames so no partial frame is seen.
// Ports:
//   clock   pixel clock
//   reset   asynchronous, active-low reset
//   bus     video_source_arbiter_if.slave (requests, grant, timing, pixels)
module video_source_arbiter #(
  parameter int N    = 4,   // sources, 2..8
  parameter int MUTE = 2,   // black frames after each grant, 0..15
  parameter int HOLD = 3    // frames shown before preemption, 0 = never
) (
  input logic                   clock,
  input logic                   reset,
  video_source_arbiter_if.slave bus
);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUTE, S_SHOW} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pick;
  logic [3:0]    count_q, count_d;
  logic [3:0]    frames_q, frames_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  others;
  logic          live_q, live_d;
  logic          vs_q;
  logic          fb;
  logic          take;
  logic          drop;
  logic [23:0]   pix_arr [N];
  logic [23:0]   rgb_q;
  logic          de_q, hs_q;

  // First requester at or after start, wrapping at N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] cand,
                                            input logic [IW-1:0] start);
    logic [IW1-1:0] idx;
    logic [IW-1:0]  sel;
    logic           found;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW1'(start) + IW1'(k);
      if (idx >= IW1'(N)) idx = idx - IW1'(N);
      if (!found && cand[idx[IW-1:0]]) begin
        sel   = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign fb     = bus.vsync_in & ~vs_q;
  // The current owner is never a candidate, so the same pick serves the
  // idle grant, the release hand-over and preemption.
  assign others = bus.req & ~grant_q;
  assign pick   = rr_pick(others, ptr_q);

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    frames_d = frames_q;
    grant_d  = grant_q;
    take     = 1'b0;
    drop     = 1'b0;

    if (fb) begin
      unique case (state_q)
        S_IDLE: take = |others;
        S_MUTE: begin
          if (!bus.req[owner_q]) begin
            drop = 1'b1;
          end else begin
            count_d = count_q - 4'd1;
            if (count_d == 4'd0) begin
              state_d  = S_SHOW;
              frames_d = '0;
            end
          end
        end
        S_SHOW: begin
          frames_d = (frames_q == 4'hf) ? frames_q : frames_q + 4'd1;
          if (!bus.req[owner_q]) begin
            drop = 1'b1;
          end else if (HOLD != 0 && int'(frames_q) + 1 >= HOLD && |others) begin
            take = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (drop) begin
        if (|others) begin
          take = 1'b1;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end

      if (take) begin
        owner_d  = pick;
        ptr_d    = (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
        grant_d  = N'(1) << pick;
        frames_d = '0;
        if (MUTE == 0) begin
          state_d = S_SHOW;
        end else begin
          state_d = S_MUTE;
          count_d = 4'(MUTE);
        end
      end
    end

    live_d = (state_d == S_SHOW);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      count_q  <= '0;
      frames_q <= '0;
      grant_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      frames_q <= frames_d;
      grant_q  <= grant_d;
      live_q   <= live_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) pix_arr[i] = bus.pix_in[24*i +: 24];
  end

  // The pixel mux looks at live_q/owner_q, i.e. the state held this cycle,
  // so on a boundary edge the outgoing owner still supplies that pixel.
  // vs_q doubles as the delayed vsync output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      vs_q  <= bus.vsync_in;
      de_q  <= bus.de_in;
      hs_q  <= bus.hsync_in;
      rgb_q <= (live_q && bus.de_in) ? pix_arr[owner_q] : 24'h000000;
    end
  end

  assign bus.grant = grant_q;
  assign bus.live  = live_q;
  assign bus.r     = rgb_q[23:16];
  assign bus.g     = rgb_q[15:8];
  assign bus.b     = rgb_q[7:0];
  assign bus.de    = de_q;
  assign bus.hsync = hs_q;
  assign bus.vsync = vs_q;
endmodule

// File: tb/tb_video_source_arbiter.sv
// Bench for video_source_arbiter. Two instances share one timing generator:
// A uses MUTE=2/HOLD=3, B uses MUTE=0/HOLD=1. A frame-level reference model
// (owner index, frames of mute left, frames shown) predicts grant/live and
// the delayed video for both on every cycle; directed steps add explicit
// expectations for reset, basic grant, preemption, release, round-robin and
// a drop during mute, followed by randomized requests.
module tb_video_source_arbiter;
  localparam int A_MUTE = 2, A_HOLD = 3;
  localparam int B_MUTE = 0, B_HOLD = 1;
  localparam int H_TOT = 12, V_TOT = 6;

  typedef struct packed {
    int owner;      // -1 when idle
    int ptr;
    int mute_left;
    int shown;
  } mdl_t;

  logic clock;
  logic reset;

  video_source_arbiter_if #(.N(4)) bus_a ();
  video_source_arbiter_if #(.N(4)) bus_b ();

  video_source_arbiter #(.N(4), .MUTE(A_MUTE), .HOLD(A_HOLD)) u_dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  video_source_arbiter #(.N(4), .MUTE(B_MUTE), .HOLD(B_HOLD)) u_dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hcnt = 0, vcnt = 0;
  logic        t_de, t_hs, t_vs;
  logic [23:0] pix_v [4];
  mdl_t        m [2];
  logic        m_vs;
  logic        fb_seen;
  logic        last_de_in;
  logic        pin_basic;
  logic [3:0]  rr_tab [5];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t grant_to(mdl_t m_in, int c, int mute);
    mdl_t n = m_in;
    n.owner     = c;
    n.ptr       = (c + 1) % 4;
    n.mute_left = mute;
    n.shown     = 0;
    return n;
  endfunction

  // One frame boundary of the arbitration rules.
  function automatic mdl_t frame_step(mdl_t m_in, logic [3:0] rq, int mute, int hold);
    mdl_t n = m_in;
    int cand = -1;
    for (int k = 0; k < 4; k++) begin
      int i = (m_in.ptr + k) % 4;
      if (cand < 0 && rq[i] && i != m_in.owner) cand = i;
    end
    if (m_in.owner < 0) begin
      if (cand >= 0) n = grant_to(n, cand, mute);
    end else if (!rq[m_in.owner]) begin
      n.owner = -1; n.mute_left = 0; n.shown = 0;
      if (cand >= 0) n = grant_to(n, cand, mute);
    end else if (m_in.mute_left > 0) begin
      n.mute_left = m_in.mute_left - 1;
    end else begin
      n.shown = (m_in.shown + 1 > 15) ? 15 : m_in.shown + 1;
      if (hold > 0 && m_in.shown + 1 >= hold && cand >= 0) n = grant_to(n, cand, mute);
    end
    return n;
  endfunction

  function automatic logic is_live(mdl_t x);
    return x.owner >= 0 && x.mute_left == 0;
  endfunction

  function automatic logic [4:0] exp_ctrl(mdl_t x);
    logic [3:0] g = '0;
    if (x.owner >= 0) g[x.owner] = 1'b1;
    return {g, is_live(x)};
  endfunction

  function automatic logic [26:0] exp_video(mdl_t x);
    logic [23:0] rgb = '0;
    if (is_live(x) && t_de) rgb = pix_v[x.owner];
    return {t_de, t_hs, t_vs, rgb};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) m[d] = '{owner: -1, ptr: 0, mute_left: 0, shown: 0};
    m_vs = 1'b0;
  endtask

  task automatic drive_inputs();
    logic [95:0] pk;
    t_de = (hcnt < 8) && (vcnt < 4);
    t_hs = (hcnt == 9) || (hcnt == 10);
    t_vs = (vcnt == V_TOT - 1);
    for (int i = 0; i < 4; i++) pix_v[i] = 24'($urandom);
    if (pin_basic) pix_v[1] = 24'hE03010;
    for (int i = 0; i < 4; i++) pk[24*i +: 24] = pix_v[i];
    bus_a.de_in = t_de; bus_a.hsync_in = t_hs; bus_a.vsync_in = t_vs; bus_a.pix_in = pk;
    bus_b.de_in = t_de; bus_b.hsync_in = t_hs; bus_b.vsync_in = t_vs; bus_b.pix_in = pk;
  endtask

  // One clock: predict, let the edge happen, compare, then move the timing.
  task automatic tick();
    logic [26:0] vid_a, vid_b;
    vid_a = exp_video(m[0]);
    vid_b = exp_video(m[1]);
    if (t_vs && !m_vs) begin
      m[0] = frame_step(m[0], bus_a.req, A_MUTE, A_HOLD);
      m[1] = frame_step(m[1], bus_b.req, B_MUTE, B_HOLD);
      fb_seen = 1'b1;
    end
    m_vs       = t_vs;
    last_de_in = t_de;
    @(posedge clock);
    #1;
    check("a_video", {bus_a.de, bus_a.hsync, bus_a.vsync, bus_a.r, bus_a.g, bus_a.b}, vid_a);
    check("a_ctrl",  {bus_a.grant, bus_a.live}, exp_ctrl(m[0]));
    check("b_video", {bus_b.de, bus_b.hsync, bus_b.vsync, bus_b.r, bus_b.g, bus_b.b}, vid_b);
    check("b_ctrl",  {bus_b.grant, bus_b.live}, exp_ctrl(m[1]));
    hcnt++;
    if (hcnt == H_TOT) begin
      hcnt = 0;
      vcnt = (vcnt + 1) % V_TOT;
    end
    drive_inputs();
  endtask

  task automatic run_to_fb();
    int k = 0;
    fb_seen = 1'b0;
    while (!fb_seen && k < 200) begin
      tick();
      k++;
    end
    if (!fb_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL fb_timeout: observed no frame boundary, required one within 200 cycles");
    end
  endtask

  task automatic check_out_zero(input string tag);
    check({tag, "_a"}, {bus_a.grant, bus_a.live, bus_a.de, bus_a.hsync, bus_a.vsync,
                        bus_a.r, bus_a.g, bus_a.b}, 32'h0);
    check({tag, "_b"}, {bus_b.grant, bus_b.live, bus_b.de, bus_b.hsync, bus_b.vsync,
                        bus_b.r, bus_b.g, bus_b.b}, 32'h0);
  endtask

  initial begin
    rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pin_basic = 1'b1;
    bus_a.req = '0;
    bus_b.req = '0;
    drive_inputs();
    model_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_out_zero("reset_state");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Basic grant on A, round-robin on B.
    bus_a.req = 4'b0010;
    bus_b.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      run_to_fb();
      check("basic_ctrl", {bus_a.grant, bus_a.live}, {4'b0010, f >= 2});
      check("rr_grant", bus_b.grant, rr_tab[f]);
      if (f == 3) begin
        for (int c = 0; c < H_TOT * V_TOT - 4; c++) begin
          tick();
          check("basic_rgb", {bus_a.r, bus_a.g, bus_a.b}, last_de_in ? 24'hE03010 : 24'h0);
        end
      end
    end
    pin_basic = 1'b0;

    // Asynchronous reset mid-frame with A showing.
    repeat (30) tick();
    #2 reset = 1'b0;
    #1 check_out_zero("reset_async");
    @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    repeat (5) tick();
    check("reset_nogrant", bus_a.grant, 4'b0000);
    run_to_fb();
    check("reset_regrant", {bus_a.grant, bus_a.live}, {4'b0010, 1'b0});
    check("reset_rr", bus_b.grant, 4'b0001);

    // Hand A to source 0, bring it to SHOW, then preempt with source 2.
    bus_a.req = 4'b0001;
    run_to_fb();
    check("pre_grant0", {bus_a.grant, bus_a.live}, {4'b0001, 1'b0});
    run_to_fb();
    run_to_fb();
    check("pre_show0", {bus_a.grant, bus_a.live}, {4'b0001, 1'b1});
    bus_a.req = 4'b0101;
    run_to_fb();
    run_to_fb();
    check("pre_hold", {bus_a.grant, bus_a.live}, {4'b0001, 1'b1});
    run_to_fb();
    check("pre_switch", {bus_a.grant, bus_a.live}, {4'b0100, 1'b0});
    bus_a.req = 4'b0100;
    run_to_fb();
    check("pre_mute2", {bus_a.grant, bus_a.live}, {4'b0100, 1'b0});
    run_to_fb();
    check("pre_show2", {bus_a.grant, bus_a.live}, {4'b0100, 1'b1});

    // Owner drops its request mid-frame.
    repeat (30) tick();
    bus_a.req = 4'b0000;
    repeat (10) tick();
    check("rel_still", {bus_a.grant, bus_a.live}, {4'b0100, 1'b1});
    run_to_fb();
    check("rel_idle", {bus_a.grant, bus_a.live}, {4'b0000, 1'b0});

    // Owner drops during its first mute frame while source 3 waits.
    bus_a.req = 4'b0001;
    run_to_fb();
    check("mdrop_g0", {bus_a.grant, bus_a.live}, {4'b0001, 1'b0});
    repeat (20) tick();
    bus_a.req = 4'b1000;
    run_to_fb();
    check("mdrop_g3", {bus_a.grant, bus_a.live}, {4'b1000, 1'b0});
    run_to_fb();
    check("mdrop_mute", {bus_a.grant, bus_a.live}, {4'b1000, 1'b0});
    run_to_fb();
    check("mdrop_show", {bus_a.grant, bus_a.live}, {4'b1000, 1'b1});

    // Randomized requests changing at arbitrary points inside frames.
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(5, 60)) tick();
      if ($urandom_range(0, 1) == 1) bus_a.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) bus_b.req = 4'($urandom_range(0, 15));
      run_to_fb();
    end
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/video_source_arbiter.md
Name: video_source_arbiter

Overview:
- Shares one video output among N pixel sources (test pattern, framebuffer, overlay generators) that are all driven by a common timing generator.
- Grants ownership only at frame boundaries (rising edge of vsync_in), using round-robin with an optional per-owner frame quantum.
- Outputs black for a programmable number of frames after every ownership change, so the output never shows a torn or partial frame.
- Sits between the timing generator and the video encoder/serializer.

Parameters:
- N, 4, number of requesting sources (2..8).
- MUTE, 2, whole frames of black output after a new grant before that source is shown (0..15).
- HOLD, 3, minimum frames an owner is shown before a pending competitor may preempt it; 0 = no preemption.

Ports:
- clock  input  1  pixel clock
- reset  input  1  asynchronous, active-low reset
- req  input  N  per-source request; level, sampled only at frame boundaries
- grant  output  N  one-hot ownership, all zero when idle
- live  output  1  high while the owner's pixels are passed through
- de_in  input  1  data enable from timing generator
- hsync_in  input  1  hsync from timing generator
- vsync_in  input  1  vsync from timing generator
- pix_in  input  N*24  source i RGB at bits [24i+23:24i], as {r,g,b}
- r  output  8  red
- g  output  8  green
- b  output  8  blue
- de  output  1  data enable
- hsync  output  1  hsync
- vsync  output  1  vsync

Behaviour:
- Reset (reset low, asynchronous, overrides every other event):
  - state IDLE; grant, live, r, g, b, de, hsync, vsync all 0.
  - vs_q = 0; round-robin pointer = 0; frame counter = 0.
- Frame boundary: fb = vsync_in & ~vs_q, where vs_q is vsync_in registered. All state and grant changes happen only on clock edges where fb = 1.
- Round-robin pick: first i with req[i] = 1, searching from pointer upward with wrap at N. After any grant, pointer = owner + 1 mod N.
- IDLE:
  - on fb with any req set: grant the pick.
  - go to MUTE with count = MUTE, or straight to SHOW if MUTE = 0.
- MUTE:
  - on fb with owner req low: release (see below).
  - else decrement count; on reaching 0 go to SHOW, clear frame counter.
- SHOW:
  - each fb increments the frame counter, saturating at 15.
  - on fb with owner req low: release.
  - else on fb with HOLD != 0, counter+1 >= HOLD, and another req pending: grant the pick among the other sources, go to MUTE.
  - else stay in SHOW.
- Release:
  - if another req is pending, grant the pick and go to MUTE (or SHOW if MUTE = 0).
  - else grant = 0 and go to IDLE.
- grant and live are registered. They change on the same edge as the state: the cycle following the fb edge sees the new values.
- Req activity between boundaries has no effect. A source must keep driving valid pixels until its grant drops.
- Datapath (latency 1 cycle, all outputs registered):
  - de/hsync/vsync = de_in/hsync_in/vsync_in delayed one cycle, passed through in every state, including IDLE.
  - {r,g,b} = owner's pix_in when live (post-update) and de_in, else 24'h000000.
  - The mux uses the state value held during the current cycle. On an fb edge the pixel register still uses the pre-transition state.
- Only one owner at any time. grant is never more than one-hot.

Test Plan:
- Reset: assert reset low mid-frame with req = 4'b0010 → all outputs 0 within the same cycle; after release, no grant until the next vsync_in rising edge.
- Basic grant (MUTE=2, pix_in[1] = 24'hE03010): req = 4'b0010 from idle.
  - grant = 4'b0010 the cycle after fb1.
  - rgb = 0 during frames 1–2.
  - live = 1 after fb3; from then on rgb = E0/30/10 wherever de = 1, and 0 where de = 0.
  - syncs and de lag their inputs by exactly 1 cycle throughout.
- Preemption (HOLD=3): source 0 in SHOW, then req = 4'b0101 → source 0 shown for exactly 3 frames, then grant = 4'b0100 and 2 black frames.
- Release: in SHOW, owner drops req mid-frame → its pixels stay visible until the next fb; then grant = 0, state IDLE, rgb = 0.
- Round-robin: req = 4'b1111 held, HOLD=1, MUTE=0 → grant sequence 0001, 0010, 0100, 1000, 0001, changing once per frame.
- Drop during MUTE: owner drops req in the first mute frame with req[3] set → grant moves to 4'b1000 at the next fb and the mute count restarts at 2.
